// File: rtl/iterative_shifter_8bit.sv
// iterative_shifter_8bit: multi-cycle 8-bit shifter (SLL/SRL/SRA/ROL), one bit position per clock.
// Optional build macro SHIFT_ZERO_BYPASS_EN: a start with smt=0 skips SHIFT and goes straight to DONE.
module iterative_shifter_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic [2:0] smt,
  input  logic [1:0] mode,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0] state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [7:0] work_q, work_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] data_out_q, data_out_d;
  logic [7:0] step;
  // One 1-bit step of the working register according to the captured mode
  always_comb begin
    step = mode_q == 2'b00 ? {work_q[6:0], 1'b0} :
           mode_q == 2'b01 ? {1'b0, work_q[7:1]} :
           mode_q == 2'b10 ? {work_q[7], work_q[7:1]} :
                             {work_q[6:0], work_q[7]};
  end
  // FSM next-state, operand capture, iteration and result load
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    work_d     = work_q;
    mode_d     = mode_q;
    data_out_d = data_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d = data_in;
          count_d = smt;
          mode_d = mode;
`ifdef SHIFT_ZERO_BYPASS_EN
          state_d = smt == 3'd0 ? DONE : SHIFT;
          data_out_d = smt == 3'd0 ? data_in : data_out_q;
`else
          state_d = SHIFT;
`endif
        end
      end
      SHIFT: begin
        if (count_q != 3'd0) begin
          work_d = step;
          count_d = count_q - 3'd1;
          state_d = count_q == 3'd1 ? DONE : SHIFT;
          data_out_d = count_q == 3'd1 ? step : data_out_q;
        end else begin
          state_d = DONE;
          data_out_d = work_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State registers with asynchronous active-low clear; an aborted result is discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= 3'd0;
      work_q     <= 8'h00;
      mode_q     <= 2'b00;
      data_out_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      work_q     <= work_d;
      mode_q     <= mode_d;
      data_out_q <= data_out_d;
    end
  end
  assign data_out = data_out_q;
  assign busy     = state_q == SHIFT;
  assign done     = state_q == DONE;
endmodule

// File: tb/tb_iterative_shifter_8bit.sv
// tb_iterative_shifter_8bit: directed vectors with a scoreboard queue checked by a done-triggered monitor.
module tb_iterative_shifter_8bit;
`ifdef SHIFT_ZERO_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] smt = 3'd0;
  logic [1:0] mode = 2'b00;
  logic [7:0] data_out;
  logic       busy;
  logic       done;

  typedef struct {
    logic [7:0] data;
    int         lat;
    int         nbusy;
    int         acc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   nb = 0;

  iterative_shifter_8bit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .smt(smt), .mode(mode), .data_out(data_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitor: counts busy cycles and checks every done against the scoreboard head
  always @(negedge clk) begin
    if (!rst_n) nb = 0;
    else begin
      if (busy) nb++;
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("data_out", data_out, e.data);
          chk("done_latency", cyc - e.acc, e.lat);
          chk("busy_cycles", nb, e.nbusy);
          chk("busy_with_done", busy, 0);
        end
        nb = 0;
      end
    end
  end

  task automatic issue(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m,
                       input logic [7:0] ed, input bit push);
    int l;
    @(posedge clk); #1;
    start = 1'b1; data_in = d; smt = s; mode = m;
    @(posedge clk); #1;
    start = 1'b0; data_in = 8'($urandom); smt = 3'($urandom); mode = 2'($urandom);
    l = (s == 3'd0) ? (BYP ? 0 : 1) : int'(s);
    if (push) sb.push_back('{ed, l, l, cyc});
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m,
                        input logic [7:0] ed);
    issue(d, s, m, ed, 1'b1);
    wait_done();
  endtask

  initial begin
    #3;
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(8'b10101010, 3'd3, 2'b00, 8'b01010000);
    run_op(8'b10101010, 3'd2, 2'b01, 8'b00101010);
    run_op(8'b11110000, 3'd1, 2'b10, 8'b11111000);
    run_op(8'b11010101, 3'd3, 2'b11, 8'b10101110);
    run_op(8'h5A, 3'd0, 2'b01, 8'h5A);
    run_op(8'h96, 3'd7, 2'b10, 8'hFF);
    run_op(8'h96, 3'd1, 2'b01, 8'h4B);
    run_op(8'h80, 3'd7, 2'b01, 8'h01);
    run_op(8'h81, 3'd1, 2'b00, 8'h02);
    run_op(8'h3C, 3'd0, 2'b11, 8'h3C);
    // second start with 8'hFF during a smt=7 rotate must be ignored
    issue(8'h81, 3'd7, 2'b11, 8'hC0, 1'b1);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; data_in = 8'hFF; smt = 3'd1; mode = 2'b00;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    repeat (6) @(negedge clk);
    // reset in the middle of SHIFT: outputs clear at once and no done follows
    issue(8'hAA, 3'd7, 2'b00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_data_out", data_out, 8'h00);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort_busy_after", busy, 0);
    run_op(8'b10101010, 3'd3, 2'b00, 8'b01010000);
    run_op(8'b11010101, 3'd3, 2'b11, 8'b10101110);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
